fir_stream_seq: RTL and testbench

- Sequencer in front of the pipelined FIR `filter` (32-bit signed x_in, 64-bit signed y_out, no enable or valid).
- Accepts a framed sample stream on a valid/ready input and drives the filter one sample per clock.
- Appends NUM_TAPS-1 zero samples to flush the convolution tail.
- Tracks pipeline latency so each filter output is tagged valid/last on an output stream.
- Holds the filter cleared between frames so every frame starts from a zero delay line.

---
 rtl/fir_stream_pkg.sv | 20 ++
 rtl/fir_tag_pipe.sv | 31 +++
 rtl/fir_stream_seq.sv | 150 +++++++++++++++
 tb/tb_fir_stream_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_pkg.sv
// Shared types and default sizing for the FIR stream sequencer and its tag pipe.
package fir_stream_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ACC_W    = 64;
    localparam int DEF_NUM_TAPS = 16;
    localparam int DEF_PIPE_LAT = 8;
    localparam int DEF_LEN_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;
endpackage

// File: rtl/fir_tag_pipe.sv
// Shift register that delays {vld,last} tags so they line up with the filter output.
module fir_tag_pipe
    import fir_stream_pkg::*;
#(
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din_vld,
    input  logic din_last,
    output logic dout_vld,
    output logic dout_last
);
    tag_t pipe [PIPE_LAT];

    // flush drops every in-flight tag so an aborted frame never reaches the output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{vld: din_vld, last: din_last};
            for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout_vld  = pipe[PIPE_LAT-1].vld;
    assign dout_last = pipe[PIPE_LAT-1].last;
endmodule

// File: rtl/fir_stream_seq.sv
// Frame sequencer for a pipelined FIR: feeds samples, flushes the tail, tags outputs.
// Optional FIR_STREAM_SEQ_UNDERRUN_CNT_EN adds a saturating starved-cycle counter.
module fir_stream_seq
    import fir_stream_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              filt_clr,
    output logic [DATA_W-1:0] filt_x,
    input  logic [ACC_W-1:0]  filt_y,
    output logic              m_valid,
    output logic [ACC_W-1:0]  m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
`ifdef FIR_STREAM_SEQ_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    output logic              underrun
);
    localparam int   TAIL_W  = $clog2(NUM_TAPS + PIPE_LAT + 1);
    localparam logic ONE_TAP = (NUM_TAPS == 1);

    state_t             state;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   slot_cnt;
    logic [TAIL_W-1:0]  tail_cnt;
    tag_t               tag_x;
    logic               zero_done;
    logic               abort_act;
    logic               start_ok;
    logic               last_slot;
    logic               last_tail;
    logic               drain_end;

    assign abort_act = abort && (state != IDLE);
    assign start_ok  = (state == IDLE) && start && !abort && (frame_len != '0);
    assign last_slot = (slot_cnt == len - LEN_W'(1));
    assign last_tail = (tail_cnt == TAIL_W'(NUM_TAPS - 2));
    assign drain_end = (tail_cnt == TAIL_W'(PIPE_LAT));

    assign s_ready  = (state == RUN);
    assign busy     = (state != IDLE);
    assign filt_clr = (state == IDLE);
    assign m_data   = filt_y;
    assign done     = m_last || zero_done;

    // tag_x sits alongside filt_x, so the pipe output lines up PIPE_LAT cycles after filt_x
    fir_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort_act),
        .din_vld   (tag_x.vld),
        .din_last  (tag_x.last),
        .dout_vld  (m_valid),
        .dout_last (m_last)
    );

    // A starved RUN slot still consumes a slot: the filter cannot stall, so it sees a zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len       <= '0;
            slot_cnt  <= '0;
            tail_cnt  <= '0;
            filt_x    <= '0;
            tag_x     <= '0;
            zero_done <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            filt_x    <= '0;
            tag_x     <= '0;
            if (abort_act) begin
                state    <= IDLE;
                slot_cnt <= '0;
                tail_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            len      <= frame_len;
                            slot_cnt <= '0;
                            underrun <= 1'b0;
                            state    <= RUN;
                        end else if (start && !abort) begin
                            zero_done <= 1'b1;
                        end
                    end
                    RUN: begin
                        filt_x <= s_valid ? s_data : '0;
                        if (!s_valid) underrun <= 1'b1;
                        tag_x <= '{vld: 1'b1, last: ONE_TAP && last_slot};
                        if (last_slot) begin
                            slot_cnt <= '0;
                            tail_cnt <= '0;
                            state    <= ONE_TAP ? DRAIN : FLUSH;
                        end else begin
                            slot_cnt <= slot_cnt + LEN_W'(1);
                        end
                    end
                    FLUSH: begin
                        tag_x <= '{vld: 1'b1, last: last_tail};
                        if (last_tail) begin
                            tail_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            tail_cnt <= tail_cnt + TAIL_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (drain_end) begin
                            tail_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            tail_cnt <= tail_cnt + TAIL_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FIR_STREAM_SEQ_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= '0;
        end else if (start_ok) begin
            underrun_cnt <= '0;
        end else if ((state == RUN) && !s_valid && !abort_act && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fir_stream_seq.sv
// Directed self-checking bench for fir_stream_seq with a behavioural 16-tap FIR (h[k]=k+1, 8-cycle latency).
module tb_fir_stream_seq;
    localparam int NT = 16;
    localparam int PL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] frame_len = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, filt_clr, m_valid, m_last, busy, done, underrun;
    logic [31:0] filt_x;
    logic [63:0] filt_y, m_data;
`ifdef FIR_STREAM_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int vcount, donecnt, lastidx, doneidx, firstcyc, donecyc;
    longint mdat [64];

    longint xh [NT-1];
    longint yp [PL];
    longint conv;

    fir_stream_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .frame_len    (frame_len),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .filt_clr     (filt_clr),
        .filt_x       (filt_x),
        .filt_y       (filt_y),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done),
`ifdef FIR_STREAM_SEQ_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Reference filter: filt_y follows filt_x by exactly PL cycles
    always_comb begin
        conv = longint'($signed(filt_x));
        for (int k = 1; k < NT; k++) conv += longint'(k + 1) * xh[k-1];
    end

    always @(posedge clk) begin
        if (filt_clr) begin
            for (int k = 0; k < NT-1; k++) xh[k] <= 0;
            for (int k = 0; k < PL; k++) yp[k] <= 0;
        end else begin
            xh[0] <= longint'($signed(filt_x));
            for (int k = 1; k < NT-1; k++) xh[k] <= xh[k-1];
            yp[0] <= conv;
            for (int k = 1; k < PL; k++) yp[k] <= yp[k-1];
        end
    end

    assign filt_y = yp[PL-1];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_obs();
        vcount = 0; donecnt = 0; lastidx = -1; doneidx = -1; firstcyc = -1; donecyc = -1;
    endtask

    task automatic observe();
        if (m_valid) begin
            if (vcount == 0) firstcyc = cyc;
            if (vcount < 64) mdat[vcount] = longint'(m_data);
            vcount++;
            if (m_last) lastidx = vcount;
        end
        if (done) begin
            donecnt++;
            doneidx = vcount;
            donecyc = cyc;
        end
    endtask

    task automatic cycle();
        tick();
        observe();
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) cycle();
        if (busy) begin
            checks++;
            $display("[TB] FAIL wait_idle: busy still %0b after %0d cycles", busy, budget);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", busy); else passed++;
        checks++; if (filt_clr !== 1'b1) $display("[TB] FAIL reset_filt_clr: got %0b want 1", filt_clr); else passed++;
        checks++; if (s_ready !== 1'b0) $display("[TB] FAIL reset_s_ready: got %0b want 0", s_ready); else passed++;
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %0b want 0", m_valid); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0b want 0", done); else passed++;
        checks++; if (underrun !== 1'b0) $display("[TB] FAIL reset_underrun: got %0b want 0", underrun); else passed++;
        checks++; if (filt_x !== 32'd0) $display("[TB] FAIL reset_filt_x: got %0h want 0", filt_x); else passed++;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_impulse(input string tag);
        int acc;
        longint exp;
        clear_obs();
        start = 1'b1; frame_len = 16'd4;
        cycle();
        start = 1'b0;
        checks++; if (s_ready !== 1'b1) $display("[TB] FAIL %s_s_ready: got %0b want 1", tag, s_ready); else passed++;
        acc = cyc;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = (i == 0) ? 32'd1 : 32'd0;
            cycle();
        end
        s_valid = 1'b0;
        wait_idle(100);
        checks++; if (vcount !== 19) $display("[TB] FAIL %s_count: got %0d want 19", tag, vcount); else passed++;
        checks++; if (firstcyc !== acc + 9) $display("[TB] FAIL %s_latency: got %0d want %0d", tag, firstcyc - acc, 9); else passed++;
        checks++; if (lastidx !== 19) $display("[TB] FAIL %s_last_idx: got %0d want 19", tag, lastidx); else passed++;
        checks++; if (donecnt !== 1 || doneidx !== 19) $display("[TB] FAIL %s_done: got %0d pulses at %0d want 1 at 19", tag, donecnt, doneidx); else passed++;
        checks++; if (cyc !== donecyc + 1) $display("[TB] FAIL %s_busy_drop: got %0d cycles after done want 1", tag, cyc - donecyc); else passed++;
        for (int i = 0; i < 19; i++) begin
            exp = (i < 16) ? longint'(i + 1) : 0;
            checks++; if (mdat[i] !== exp) $display("[TB] FAIL %s_data[%0d]: got %0d want %0d", tag, i, mdat[i], exp); else passed++;
        end
    endtask

    task automatic test_underrun();
        longint xs [8];
        longint exp;
        clear_obs();
        start = 1'b1; frame_len = 16'd8;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = !(i >= 2 && i < 5);
            s_data = 32'(i + 1);
            xs[i] = (i >= 2 && i < 5) ? 0 : longint'(i + 1);
            cycle();
        end
        s_valid = 1'b0;
        wait_idle(100);
        checks++; if (underrun !== 1'b1) $display("[TB] FAIL underrun_flag: got %0b want 1", underrun); else passed++;
        checks++; if (vcount !== 23) $display("[TB] FAIL underrun_count: got %0d want 23", vcount); else passed++;
        checks++; if (lastidx !== 23 || donecnt !== 1) $display("[TB] FAIL underrun_last: got last %0d done %0d want 23 and 1", lastidx, donecnt); else passed++;
`ifdef FIR_STREAM_SEQ_UNDERRUN_CNT_EN
        checks++; if (underrun_cnt !== 16'd3) $display("[TB] FAIL underrun_cnt: got %0d want 3", underrun_cnt); else passed++;
`endif
        for (int n = 0; n < 23; n++) begin
            exp = 0;
            for (int k = 0; k < NT; k++)
                if (n - k >= 0 && n - k < 8) exp += longint'(k + 1) * xs[n-k];
            checks++; if (mdat[n] !== exp) $display("[TB] FAIL underrun_data[%0d]: got %0d want %0d", n, mdat[n], exp); else passed++;
        end
    endtask

    task automatic test_start_busy();
        clear_obs();
        start = 1'b1; frame_len = 16'd3;
        cycle();
        start = 1'b0;
        checks++; if (underrun !== 1'b0) $display("[TB] FAIL start_clears_underrun: got %0b want 0", underrun); else passed++;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data = 32'(i + 2);
            start = (i == 1);
            frame_len = (i == 1) ? 16'd2 : 16'd3;
            cycle();
        end
        start = 1'b0; s_valid = 1'b0;
        wait_idle(100);
        repeat (5) cycle();
        checks++; if (vcount !== 18) $display("[TB] FAIL start_busy_count: got %0d want 18", vcount); else passed++;
        checks++; if (lastidx !== 18 || donecnt !== 1) $display("[TB] FAIL start_busy_last: got last %0d done %0d want 18 and 1", lastidx, donecnt); else passed++;
    endtask

    task automatic test_abort();
        clear_obs();
        start = 1'b1; frame_len = 16'd2;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 32'd9;
            cycle();
        end
        s_valid = 1'b0;
        for (int k = 0; k < 40 && !m_valid; k++) cycle();
        checks++; if (m_valid !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL abort_pre: got m_valid %0b busy %0b want 1 1", m_valid, busy); else passed++;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL abort_m_valid: got %0b want 0", m_valid); else passed++;
        checks++; if (filt_clr !== 1'b1) $display("[TB] FAIL abort_filt_clr: got %0b want 1", filt_clr); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %0b want 0", busy); else passed++;
        clear_obs();
        repeat (30) cycle();
        checks++; if (vcount !== 0 || donecnt !== 0) $display("[TB] FAIL abort_quiet: got %0d outputs %0d done want 0 0", vcount, donecnt); else passed++;
        start = 1'b1; abort = 1'b1; frame_len = 16'd5;
        cycle();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_wins_start: got busy %0b want 0", busy); else passed++;
        test_impulse("after_abort");
    endtask

    task automatic test_reset_drain();
        clear_obs();
        start = 1'b1; frame_len = 16'd1;
        cycle();
        start = 1'b0;
        s_valid = 1'b0;
        cycle();
        repeat (19) cycle();
        checks++; if (busy !== 1'b1 || m_valid !== 1'b1 || underrun !== 1'b1) $display("[TB] FAIL drain_pre: got busy %0b m_valid %0b underrun %0b want 1 1 1", busy, m_valid, underrun); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || done !== 1'b0) $display("[TB] FAIL rst_drain_out: got busy %0b m_valid %0b m_last %0b done %0b want 0 0 0 0", busy, m_valid, m_last, done); else passed++;
        checks++; if (filt_clr !== 1'b1 || s_ready !== 1'b0 || filt_x !== 32'd0) $display("[TB] FAIL rst_drain_ctl: got clr %0b ready %0b x %0h want 1 0 0", filt_clr, s_ready, filt_x); else passed++;
        checks++; if (underrun !== 1'b0) $display("[TB] FAIL rst_drain_underrun: got %0b want 0", underrun); else passed++;
        repeat (2) tick();
        rst = 1'b1;
        clear_obs();
        repeat (30) cycle();
        checks++; if (vcount !== 0 || busy !== 1'b0) $display("[TB] FAIL rst_drain_quiet: got %0d outputs busy %0b want 0 0", vcount, busy); else passed++;
    endtask

    task automatic test_zero_len();
        int clr_low;
        clr_low = 0;
        clear_obs();
        start = 1'b1; frame_len = 16'd0;
        cycle();
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL zero_done: got done %0b busy %0b want 1 0", done, busy); else passed++;
        repeat (10) begin
            cycle();
            if (!filt_clr) clr_low++;
        end
        checks++; if (donecnt !== 1) $display("[TB] FAIL zero_done_count: got %0d want 1", donecnt); else passed++;
        checks++; if (vcount !== 0) $display("[TB] FAIL zero_outputs: got %0d want 0", vcount); else passed++;
        checks++; if (clr_low !== 0) $display("[TB] FAIL zero_filt_clr: got %0d low cycles want 0", clr_low); else passed++;
    endtask

    initial begin
        test_reset();
        test_impulse("impulse");
        test_underrun();
        test_start_busy();
        test_abort();
        test_reset_drain();
        test_zero_len();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
